// File: rtl/map_draw_sched_if.sv
// Plot-bus bundle for map_draw_sched: redraw control, sprite request
// channel, obstacle ROM port and the VGA plot outputs.
// master = scheduler side, slave = processor/ROM/VGA side.
interface map_draw_sched_if;
   logic       redraw_start;
   logic       busy;
   logic       done;
   logic       spr_req;
   logic [7:0] spr_x;
   logic [7:0] spr_y;
   logic [2:0] spr_color;
   logic       spr_ack;
   logic [7:0] obs_x;
   logic [7:0] obs_y;
   logic [2:0] obs_mem;
   logic [7:0] x;
   logic [7:0] y;
   logic [2:0] color_draw;
   logic       plot;

   modport master (
      input  redraw_start, spr_req, spr_x, spr_y, spr_color, obs_mem,
      output busy, done, spr_ack, obs_x, obs_y, x, y, color_draw, plot
   );

   modport slave (
      output redraw_start, spr_req, spr_x, spr_y, spr_color, obs_mem,
      input  busy, done, spr_ack, obs_x, obs_y, x, y, color_draw, plot
   );
endinterface

// File: rtl/map_draw_sched.sv
// map_draw_sched: raster-order redraw of the obstacle map from ROM onto the
// VGA plot bus, sharing each issue slot with single-pixel sprite requests.
// Every granted slot enters a ROM_LAT-deep delay line so the ROM data and
// the sprite pixels reach the registered plot outputs in issue order.
// Optional build macro SKIP_BG_EN: map pixels of colour 0 are not plotted.
module map_draw_sched #(
   parameter int MAP_W   = 160,
   parameter int MAP_H   = 120,
   parameter int ROM_LAT = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   map_draw_sched_if.master bus
);
   localparam int LAST = ROM_LAT - 1;
   localparam int DCW  = $clog2(ROM_LAT + 1) + 1;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   state_t         state;
   logic [7:0]     cnt_x, cnt_y;
   logic [7:0]     obs_x_q, obs_y_q;
   logic           prev_map;
   logic           busy_q;
   logic [DCW-1:0] drain_cnt;

   logic spr_grant, map_grant, last_issue, bg;

   // Delay line: one entry per issue slot, stage LAST lines up with obs_mem
   logic       vld_p  [ROM_LAT];
   logic       src_p  [ROM_LAT];   // 1 = sprite, 0 = map
   logic       last_p [ROM_LAT];
   logic [7:0] x_p    [ROM_LAT];
   logic [7:0] y_p    [ROM_LAT];
   logic [2:0] col_p  [ROM_LAT];

   logic       plot_q, done_q;
   logic [7:0] x_q, y_q;
   logic [2:0] color_q;

   // Slot arbitration: sprites always win outside SCAN; inside SCAN they
   // only win right after a map slot, so contention alternates map/sprite.
   assign spr_grant  = reset_n && bus.spr_req && (state != SCAN || prev_map);
   assign map_grant  = reset_n && (state == SCAN) && !spr_grant;
   assign last_issue = map_grant && (cnt_x == 8'(MAP_W - 1)) && (cnt_y == 8'(MAP_H - 1));

`ifdef SKIP_BG_EN
   assign bg = !src_p[LAST] && (bus.obs_mem == 3'b000);
`else
   assign bg = 1'b0;
`endif

   // The ROM address is presented in the same cycle as the grant and holds
   // the last issued address on non-map slots.
   assign bus.obs_x      = map_grant ? cnt_x : obs_x_q;
   assign bus.obs_y      = map_grant ? cnt_y : obs_y_q;
   assign bus.spr_ack    = spr_grant;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.plot       = plot_q;
   assign bus.x          = x_q;
   assign bus.y          = y_q;
   assign bus.color_draw = color_q;

   // Control FSM: redraw sequencing, raster counters and address hold
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt_x     <= '0;
         cnt_y     <= '0;
         obs_x_q   <= '0;
         obs_y_q   <= '0;
         prev_map  <= 1'b0;
         busy_q    <= 1'b0;
         drain_cnt <= '0;
      end else begin
         if (map_grant) begin
            obs_x_q <= cnt_x;
            obs_y_q <= cnt_y;
            if (cnt_x == 8'(MAP_W - 1)) begin
               cnt_x <= '0;
               cnt_y <= cnt_y + 8'd1;
            end else begin
               cnt_x <= cnt_x + 8'd1;
            end
         end
         case (state)
            IDLE: begin
               if (bus.redraw_start) begin
                  state    <= SCAN;
                  cnt_x    <= '0;
                  cnt_y    <= '0;
                  prev_map <= 1'b0;
                  busy_q   <= 1'b1;
               end
            end
            SCAN: begin
               prev_map <= map_grant;
               if (last_issue) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end
            end
            DRAIN: begin
               // Lasts until the final map entry has left the output stage
               if (drain_cnt == DCW'(ROM_LAT)) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Delay line valid bits: flushed on reset so no in-flight pixel survives
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < ROM_LAT; i++) vld_p[i] <= 1'b0;
      end else begin
         vld_p[0] <= spr_grant || map_grant;
         for (int i = 1; i < ROM_LAT; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   // Delay line payload: source, coordinates, sprite colour, last-pixel tag
   always_ff @(posedge clk) begin
      src_p[0]  <= spr_grant;
      last_p[0] <= last_issue;
      x_p[0]    <= spr_grant ? bus.spr_x : cnt_x;
      y_p[0]    <= spr_grant ? bus.spr_y : cnt_y;
      col_p[0]  <= bus.spr_color;
      for (int i = 1; i < ROM_LAT; i++) begin
         src_p[i]  <= src_p[i-1];
         last_p[i] <= last_p[i-1];
         x_p[i]    <= x_p[i-1];
         y_p[i]    <= y_p[i-1];
         col_p[i]  <= col_p[i-1];
      end
   end

   // Output stage: merge ROM data, register plot strobe and done pulse
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         plot_q  <= 1'b0;
         done_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         color_q <= '0;
      end else begin
         plot_q <= vld_p[LAST] && !bg;
         done_q <= vld_p[LAST] && last_p[LAST];
         if (vld_p[LAST] && !bg) begin
            x_q     <= x_p[LAST];
            y_q     <= y_p[LAST];
            color_q <= src_p[LAST] ? col_p[LAST] : bus.obs_mem;
         end
      end
   end
endmodule

// File: tb/tb_map_draw_sched.sv
// Directed bench for map_draw_sched on a 4x2 map, ROM_LAT=1, ROM data x+y.
// Covers reset, uncontended redraw, ignored restart, mid-redraw reset and
// restart, idle sprite pixels and map/sprite contention.
module tb_map_draw_sched;
   logic clk = 1'b0;
   logic reset_n;
   int   n_chk = 0;
   int   n_err = 0;

   map_draw_sched_if bus_if();

   map_draw_sched #(.MAP_W(4), .MAP_H(2), .ROM_LAT(1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   always #5 clk = ~clk;

   // One-cycle ROM returning x+y
   always @(posedge clk) bus_if.obs_mem <= 3'(bus_if.obs_x + bus_if.obs_y);

   // Map colours in raster order for the x+y ROM
   int col_tab [8] = '{0, 1, 2, 3, 1, 2, 3, 4};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit map_plotted(input int k);
`ifdef SKIP_BG_EN
      return col_tab[k] != 0;
`else
      return 1'b1;
`endif
   endfunction

   // Uncontended redraw; optional second redraw_start at cycle 4 and
   // optional reset pulse at cycle rst_cyc (-1 = none)
   task automatic scan_run(input bit repulse, input int rst_cyc);
      bit post;
      bit ep;
      int k;
      for (int c = 0; c <= 12; c++) begin
         bus_if.redraw_start = (c == 0) || (repulse && c == 4);
         reset_n = !(rst_cyc >= 0 && c == rst_cyc);
         post = (rst_cyc >= 0 && c > rst_cyc);
         @(negedge clk);
         if (post) begin
            check($sformatf("rst_busy@%0d", c), bus_if.busy, 0);
            check($sformatf("rst_done@%0d", c), bus_if.done, 0);
            check($sformatf("rst_plot@%0d", c), bus_if.plot, 0);
            if (c == rst_cyc + 1) begin
               check("rst_x", bus_if.x, 0);
               check("rst_y", bus_if.y, 0);
               check("rst_color", bus_if.color_draw, 0);
               check("rst_obs_x", bus_if.obs_x, 0);
               check("rst_obs_y", bus_if.obs_y, 0);
               check("rst_ack", bus_if.spr_ack, 0);
            end
         end else begin
            k  = c - 3;
            ep = (c >= 3 && c <= 10) && map_plotted(k);
            check($sformatf("busy@%0d", c), bus_if.busy, (c >= 1 && c <= 10));
            check($sformatf("done@%0d", c), bus_if.done, (c == 10));
            check($sformatf("plot@%0d", c), bus_if.plot, ep);
            if (ep) begin
               check($sformatf("x@%0d", c), bus_if.x, k % 4);
               check($sformatf("y@%0d", c), bus_if.y, k / 4);
               check($sformatf("color@%0d", c), bus_if.color_draw, col_tab[k]);
            end
            if (c >= 1 && c <= 8 && (rst_cyc < 0 || c < rst_cyc)) begin
               check($sformatf("obs_x@%0d", c), bus_if.obs_x, (c - 1) % 4);
               check($sformatf("obs_y@%0d", c), bus_if.obs_y, (c - 1) / 4);
            end
         end
         @(posedge clk); #1;
      end
      bus_if.redraw_start = 1'b0;
      reset_n = 1'b1;
   endtask

   // Three back-to-back sprite pixels while idle, last one colour 0
   task automatic sprite_idle();
      logic [7:0] sx [3] = '{8'd10, 8'd11, 8'd12};
      logic [7:0] sy [3] = '{8'd20, 8'd21, 8'd22};
      logic [2:0] sc [3] = '{3'd1, 3'd2, 3'd0};
      for (int c = 0; c <= 5; c++) begin
         bus_if.spr_req = (c < 3);
         if (c < 3) begin
            bus_if.spr_x     = sx[c];
            bus_if.spr_y     = sy[c];
            bus_if.spr_color = sc[c];
         end
         @(negedge clk);
         check($sformatf("idle_ack@%0d", c), bus_if.spr_ack, (c < 3));
         check($sformatf("idle_busy@%0d", c), bus_if.busy, 0);
         check($sformatf("idle_plot@%0d", c), bus_if.plot, (c >= 2 && c <= 4));
         if (c >= 2 && c <= 4) begin
            check($sformatf("idle_x@%0d", c), bus_if.x, sx[c-2]);
            check($sformatf("idle_y@%0d", c), bus_if.y, sy[c-2]);
            check($sformatf("idle_color@%0d", c), bus_if.color_draw, sc[c-2]);
         end
         @(posedge clk); #1;
      end
      bus_if.spr_req = 1'b0;
   endtask

   // Redraw with a sprite requester holding spr_req for three pixels
   task automatic contend();
      int src_tab [11] = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
      int acks = 0;
      int mk   = 0;
      bit ep;
      bus_if.spr_x     = 8'd50;
      bus_if.spr_y     = 8'd60;
      bus_if.spr_color = 3'd5;
      for (int c = 0; c <= 15; c++) begin
         bus_if.redraw_start = (c == 0);
         bus_if.spr_req      = (c >= 1 && acks < 3);
         @(negedge clk);
         check($sformatf("c_ack@%0d", c), bus_if.spr_ack, (c == 2 || c == 4 || c == 6));
         if (bus_if.spr_ack) acks++;
         check($sformatf("c_busy@%0d", c), bus_if.busy, (c >= 1 && c <= 13));
         check($sformatf("c_done@%0d", c), bus_if.done, (c == 13));
         if (c >= 3 && c <= 13 && src_tab[c-3] == 1) begin
            check($sformatf("c_plot@%0d", c), bus_if.plot, 1);
            check($sformatf("c_sx@%0d", c), bus_if.x, 50);
            check($sformatf("c_sy@%0d", c), bus_if.y, 60);
            check($sformatf("c_scol@%0d", c), bus_if.color_draw, 5);
         end else if (c >= 3 && c <= 13) begin
            ep = map_plotted(mk);
            check($sformatf("c_plot@%0d", c), bus_if.plot, ep);
            if (ep) begin
               check($sformatf("c_mx@%0d", c), bus_if.x, mk % 4);
               check($sformatf("c_my@%0d", c), bus_if.y, mk / 4);
               check($sformatf("c_mcol@%0d", c), bus_if.color_draw, col_tab[mk]);
            end
            mk++;
         end else begin
            check($sformatf("c_plot@%0d", c), bus_if.plot, 0);
         end
         @(posedge clk); #1;
      end
      bus_if.redraw_start = 1'b0;
      bus_if.spr_req      = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n             = 1'b0;
      bus_if.redraw_start = 1'b0;
      bus_if.spr_req      = 1'b0;
      bus_if.spr_x        = '0;
      bus_if.spr_y        = '0;
      bus_if.spr_color    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", bus_if.busy, 0);
      check("reset_done", bus_if.done, 0);
      check("reset_ack", bus_if.spr_ack, 0);
      check("reset_obs_x", bus_if.obs_x, 0);
      check("reset_obs_y", bus_if.obs_y, 0);
      check("reset_x", bus_if.x, 0);
      check("reset_y", bus_if.y, 0);
      check("reset_color", bus_if.color_draw, 0);
      check("reset_plot", bus_if.plot, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      scan_run(1'b0, -1);
      scan_run(1'b1, -1);
      scan_run(1'b0, 5);
      scan_run(1'b0, -1);
      sprite_idle();
      contend();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/map_draw_sched.md
Name: map_draw_sched

Overview:
- Sequences a full-screen redraw of the obstacle map from the obstacle ROM onto the VGA plot bus.
- Walks the ROM address space in raster order and pipelines each ROM read into a registered plot output.
- Shares the single plot bus between this map scan and single-pixel sprite requests from the processor.
- Sits between processor, rom and the VGA adapter. It owns obs_x/obs_y and the x/y/color_draw/plot outputs.

Parameters:
MAP_W, 160, map width in pixels (1..256)
MAP_H, 120, map height in pixels (1..256)
ROM_LAT, 1, ROM read latency in cycles from address to obs_mem valid (≥1)

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous reset, active-low
redraw_start  input  1  one-cycle request to begin a full map redraw
busy  output  1  high while a redraw is in progress
done  output  1  one-cycle pulse when the final map pixel reaches the output
spr_req  input  1  sprite pixel request; held high until acknowledged
spr_x  input  8  sprite pixel x
spr_y  input  8  sprite pixel y
spr_color  input  3  sprite pixel colour
spr_ack  output  1  one-cycle pulse; the request is consumed this cycle
obs_x  output  8  ROM x address
obs_y  output  8  ROM y address
obs_mem  input  3  ROM data, valid ROM_LAT cycles after address
x  output  8  plot x
y  output  8  plot y
color_draw  output  3  plot colour
plot  output  1  pixel write strobe

Behaviour:
- Clock and reset: one clock, clk; synchronous active-low reset, reset_n.
- Reset (reset_n low at a clk edge):
  - state=IDLE.
  - All outputs are 0: busy, done, spr_ack, obs_x, obs_y, x, y, color_draw, plot.
  - The delay line is flushed (all valid bits 0) and the scan counters are 0.
  - Reset mid-redraw aborts it: no done pulse, and no in-flight pixel is plotted.
- States:
  - IDLE: redraw_start=1 → SCAN, with counters at (0,0). busy goes high on the next cycle.
  - SCAN: each cycle is one issue slot, granted to map or sprite (arbitration below).
    - A map grant drives obs_x/obs_y with the counter value, pushes {valid,src=map,x,y} into the delay line, and advances the counter in raster order: x increments; at MAP_W-1, x wraps to 0 and y increments.
    - The issue of (MAP_W-1, MAP_H-1) → DRAIN.
  - DRAIN: lasts ROM_LAT+1 cycles; sprite slots are still served. Then → IDLE.
- done timing: done pulses in the same cycle the final map pixel's plot-out slot occurs. busy falls the cycle after done.
- redraw_start while busy is ignored.
- obs_x/obs_y hold their last value on non-map slots.
- Arbitration:
  - IDLE/DRAIN: every cycle with spr_req=1 is a sprite grant.
  - SCAN: if spr_req=1 and the previous SCAN slot was a map grant → sprite grant; otherwise → map grant. Under contention grants strictly alternate. With no spr_req, the map takes every slot.
- Sprite grant:
  - spr_ack=1 that cycle.
  - Pushes {valid,src=spr,spr_x,spr_y,spr_color} into the delay line.
  - A requester holding spr_req after ack gets its next pixel no earlier than the next slot.
- Delay line:
  - Length ROM_LAT; output registered.
  - Entry issued in cycle a → x/y/color_draw/plot driven in cycle a+ROM_LAT+1.
  - color_draw = spr colour for src=spr, obs_mem for src=map (sampled at a+ROM_LAT).
  - plot = the valid bit. Exactly one pixel per slot; no collisions.
  - When plot=0, x/y/color_draw hold their values.
- Throughput: uncontended redraw gives MAP_W*MAP_H plots in consecutive cycles.

Optional Feature:
SKIP_BG_EN
- Defined: map pixels whose obs_mem==3'b000 are not plotted (plot=0 in that slot).
  - Slot timing, ordering and done are unchanged.
  - Sprite pixels are always plotted, even with colour 0.
- Undefined: every map pixel is plotted, including colour 0.

Test Plan:
- MAP_W=4, MAP_H=2, ROM_LAT=1; ROM returns x+y; redraw_start at cycle 0, no sprites →
  - obs addresses (0,0)…(3,1) issued in cycles 1–8.
  - plot high cycles 3–10 with color_draw 0,1,2,3,1,2,3,4.
  - done=1 at cycle 10; busy high cycles 1–10.
- Same config; spr_req held from cycle 1 with (50,60,5); drop it after 3 acks →
  - Acks at cycles 2,4,6.
  - Map/sprite plots alternate starting at cycle 3.
  - All 8 map pixels plotted in raster order; done at cycle 13.
- IDLE; spr_req=1 for 3 consecutive pixels →
  - spr_ack in 3 consecutive cycles.
  - plot 2 cycles after each ack with the matching x/y/color.
- reset_n=0 at cycle 5 of the first scenario →
  - Next cycle: all outputs 0.
  - No further plot or done.
  - A new redraw_start restarts from (0,0).
- redraw_start pulsed again at cycle 4 of the first scenario → ignored; exactly one done, at cycle 10.
- SKIP_BG_EN defined, first scenario → plot low at cycle 3 (colour 0); the other 7 plots are unchanged; done still at cycle 10.
